// File: rtl/id_ex_if.sv
// id_ex_if: valid/ready bus carrying one decoded instruction between pipeline stages.
// Rev 1.0
`default_nettype none

interface id_ex_if #(
    parameter int XLEN   = 32,
    parameter int SIDE_W = 8
);
    logic              valid;
    logic              ready;
    logic [XLEN-1:0]   inst;
    logic [XLEN-1:0]   inst_addr;
    logic [XLEN-1:0]   op_num1;
    logic [XLEN-1:0]   op_num2;
    logic [4:0]        rd_addr;
    logic              reg_wen;
    logic [SIDE_W-1:0] side;

    modport master (
        output valid, inst, inst_addr, op_num1, op_num2, rd_addr, reg_wen, side,
        input  ready
    );

    modport slave (
        input  valid, inst, inst_addr, op_num1, op_num2, rd_addr, reg_wen, side,
        output ready
    );
endinterface

`default_nettype wire

// File: rtl/id_ex_pipe_stage.sv
// id_ex_pipe_stage: ID->EX register slice with flush-to-bubble, optional skid entry and stall counter.
// Rev 1.0
`default_nettype none

module id_ex_pipe_stage #(
    parameter int               XLEN     = 32,
    parameter int               SIDE_W   = 8,
    parameter bit               SKID_EN  = 1'b1,
    parameter logic [XLEN-1:0]  NOP_INST = 32'h0000_0013,
    parameter int               CNT_W    = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush_i,
    id_ex_if.slave                in_if,
    id_ex_if.master               out_if,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam int PW = 4 * XLEN + 5 + 1 + SIDE_W;
    // An empty stage must look like a harmless NOP to EX.
    localparam logic [PW-1:0] BUBBLE = {NOP_INST, {(PW - XLEN){1'b0}}};

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    logic [PW-1:0]    w_in_pl;
    logic [PW-1:0]    main_q;
    logic             out_valid_q;
    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [CNT_W-1:0] stall_q;

    assign w_in_pl = {in_if.inst, in_if.inst_addr, in_if.op_num1, in_if.op_num2,
                      in_if.rd_addr, in_if.reg_wen, in_if.side};

    assign w_in_fire   = in_if.valid & w_in_ready;
    assign w_out_fire  = out_valid_q & out_if.ready;
    assign in_if.ready = w_in_ready;

    assign out_if.valid = out_valid_q;
    assign {out_if.inst, out_if.inst_addr, out_if.op_num1, out_if.op_num2,
            out_if.rd_addr, out_if.reg_wen, out_if.side} = main_q;

    generate
        if (SKID_EN) begin : g_skid
            state_t        state_q;
            logic [PW-1:0] skid_q;
            logic          in_ready_q;

            assign w_in_ready = in_ready_q;

            always_ff @(posedge clk) begin
                if (rst || flush_i) begin
                    state_q     <= S_EMPTY;
                    main_q      <= BUBBLE;
                    skid_q      <= BUBBLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end else begin
                    case (state_q)
                        S_EMPTY: begin
                            if (w_in_fire) begin
                                main_q      <= w_in_pl;
                                out_valid_q <= 1'b1;
                                state_q     <= S_FULL;
                            end
                        end
                        S_FULL: begin
                            case ({w_in_fire, w_out_fire})
                                2'b11: main_q <= w_in_pl;
                                2'b10: begin
                                    skid_q     <= w_in_pl;
                                    in_ready_q <= 1'b0;
                                    state_q    <= S_SKID;
                                end
                                2'b01: begin
                                    main_q      <= BUBBLE;
                                    out_valid_q <= 1'b0;
                                    state_q     <= S_EMPTY;
                                end
                                default: ;
                            endcase
                        end
                        S_SKID: begin
                            // Skid entry only ever moves into main, so order is kept.
                            if (w_out_fire) begin
                                main_q     <= skid_q;
                                skid_q     <= BUBBLE;
                                in_ready_q <= 1'b1;
                                state_q    <= S_FULL;
                            end
                        end
                        default: begin
                            state_q     <= S_EMPTY;
                            main_q      <= BUBBLE;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_single
            assign w_in_ready = ~out_valid_q | out_if.ready;

            always_ff @(posedge clk) begin
                if (rst || flush_i) begin
                    main_q      <= BUBBLE;
                    out_valid_q <= 1'b0;
                end else if (w_in_fire) begin
                    main_q      <= w_in_pl;
                    out_valid_q <= 1'b1;
                end else if (w_out_fire) begin
                    main_q      <= BUBBLE;
                    out_valid_q <= 1'b0;
                end
            end
        end
    endgenerate

    // Flush does not mask the count: a stalled cycle is still a stalled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid_q && !out_if.ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe_stage.sv
// tb_id_ex_pipe_stage: scoreboard bench driving a SKID_EN=0/CNT_W=4 and a SKID_EN=1/CNT_W=16 stage in parallel.
// Rev 1.0
`default_nettype none

module tb_id_ex_pipe_stage;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        wen;
        logic [7:0]  side;
    } pkt_t;

    logic clk = 1'b0;
    logic rst, flush, in_v, out_rdy;
    pkt_t pin;

    logic [3:0]  cnt0;
    logic [15:0] cnt1;

    pkt_t sb [2][$];
    int   scnt [2];
    int   cmax [2] = '{15, 65535};
    bit   model_ok = 1'b0;
    int   ncmp = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    id_ex_if #(.XLEN(32), .SIDE_W(8)) in0 ();
    id_ex_if #(.XLEN(32), .SIDE_W(8)) out0 ();
    id_ex_if #(.XLEN(32), .SIDE_W(8)) in1 ();
    id_ex_if #(.XLEN(32), .SIDE_W(8)) out1 ();

    assign in0.valid = in_v;      assign in1.valid = in_v;
    assign in0.inst = pin.inst;   assign in1.inst = pin.inst;
    assign in0.inst_addr = pin.addr; assign in1.inst_addr = pin.addr;
    assign in0.op_num1 = pin.op1; assign in1.op_num1 = pin.op1;
    assign in0.op_num2 = pin.op2; assign in1.op_num2 = pin.op2;
    assign in0.rd_addr = pin.rd;  assign in1.rd_addr = pin.rd;
    assign in0.reg_wen = pin.wen; assign in1.reg_wen = pin.wen;
    assign in0.side = pin.side;   assign in1.side = pin.side;
    assign out0.ready = out_rdy;  assign out1.ready = out_rdy;

    id_ex_pipe_stage #(.XLEN(32), .SIDE_W(8), .SKID_EN(1'b0), .NOP_INST(32'h13), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .flush_i(flush), .in_if(in0), .out_if(out0), .stall_cnt_o(cnt0)
    );

    id_ex_pipe_stage #(.XLEN(32), .SIDE_W(8), .SKID_EN(1'b1), .NOP_INST(32'h13), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .flush_i(flush), .in_if(in1), .out_if(out1), .stall_cnt_o(cnt1)
    );

    function automatic pkt_t bubble();
        pkt_t b;
        b = '0;
        b.inst = 32'h0000_0013;
        return b;
    endfunction

    function automatic pkt_t outp(int k);
        pkt_t p;
        if (k == 0) p = '{out0.inst, out0.inst_addr, out0.op_num1, out0.op_num2, out0.rd_addr, out0.reg_wen, out0.side};
        else        p = '{out1.inst, out1.inst_addr, out1.op_num1, out1.op_num2, out1.rd_addr, out1.reg_wen, out1.side};
        return p;
    endfunction

    function automatic pkt_t rnd_pkt();
        pkt_t p;
        p.inst = $urandom; p.addr = $urandom; p.op1 = $urandom; p.op2 = $urandom;
        p.rd = 5'($urandom); p.wen = 1'($urandom); p.side = 8'($urandom);
        return p;
    endfunction

    task automatic chk(string tag, logic [159:0] obs, logic [159:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit v, pkt_t p);
        in_v = v;
        pin  = p;
    endtask

    // Compare every output of both stages to the model, then advance the model over one edge.
    task automatic tick();
        logic ov, ir;
        logic [15:0] cnt;
        bit   exp_rdy;
        int   sz;
        #1;
        for (int k = 0; k < 2; k++) begin
            ov  = (k == 0) ? out0.valid : out1.valid;
            ir  = (k == 0) ? in0.ready  : in1.ready;
            cnt = (k == 0) ? {12'd0, cnt0} : cnt1;
            sz  = sb[k].size();
            exp_rdy = (k == 0) ? (sz == 0 || out_rdy) : (sz < 2);
            if (model_ok) begin
                chk($sformatf("dut%0d.out_valid", k), ov, sz != 0);
                chk($sformatf("dut%0d.payload", k), outp(k), (sz != 0) ? sb[k][0] : bubble());
                chk($sformatf("dut%0d.stall_cnt", k), cnt, scnt[k]);
                if (!rst) chk($sformatf("dut%0d.in_ready", k), ir, exp_rdy);
            end
            if (rst) begin
                sb[k].delete();
                scnt[k] = 0;
            end else begin
                if (sz != 0 && !out_rdy && scnt[k] < cmax[k]) scnt[k]++;
                if (sz != 0 && out_rdy) void'(sb[k].pop_front());
                if (flush) sb[k].delete();
                else if (in_v && exp_rdy) sb[k].push_back(pin);
            end
        end
        if (rst) model_ok = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        pkt_t a, b, c;
        rst = 1'b1; flush = 1'b0; out_rdy = 1'b0;
        drive(1'b0, '0);
        @(posedge clk); #1;

        // Reset
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset.inst", out1.inst, 32'h13);
        chk("reset.reg_wen", out1.reg_wen, 1'b0);
        chk("reset.in_ready", in1.ready, 1'b1);
        chk("reset.stall_cnt", cnt1, 16'd0);

        // Streaming at full rate
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, rnd_pkt());
            tick();
        end
        drive(1'b0, '0);
        tick(); tick();
        chk("stream.stall_cnt", cnt1, 16'd0);

        // Fill main and skid while EX stalls
        out_rdy = 1'b0;
        a = rnd_pkt(); b = rnd_pkt();
        drive(1'b1, a); tick();
        drive(1'b1, b); tick();
        drive(1'b0, '0);
        #1;
        chk("skid.in_ready", in1.ready, 1'b0);
        chk("skid.head", outp(1), a);
        out_rdy = 1'b1;
        tick(); tick(); tick();

        // Flush while skid is occupied, C offered in the flush cycle
        out_rdy = 1'b0;
        drive(1'b1, rnd_pkt()); tick();
        drive(1'b1, rnd_pkt()); tick();
        c = rnd_pkt();
        flush = 1'b1; drive(1'b1, c); tick();
        flush = 1'b0; drive(1'b0, '0);
        chk("flush.out_valid", out1.valid, 1'b0);
        chk("flush.inst", out1.inst, 32'h13);
        out_rdy = 1'b1;
        tick(); tick();

        // Stall counting and saturation from a clean reset
        rst = 1'b1; tick(); rst = 1'b0;
        out_rdy = 1'b0;
        a = rnd_pkt();
        drive(1'b1, a); tick();
        drive(1'b0, '0);
        for (int i = 0; i < 10; i++) tick();
        chk("stall10.cnt1", cnt1, 16'd10);
        chk("stall10.cnt0", cnt0, 4'd10);
        chk("stall10.hold", outp(1), a);
        for (int i = 0; i < 10; i++) tick();
        chk("stall20.cnt0_sat", cnt0, 4'hF);
        chk("stall20.cnt1", cnt1, 16'd20);
        out_rdy = 1'b1;
        tick(); tick();

        // Random traffic with occasional flush and one mid-stream reset
        for (int i = 0; i < 600; i++) begin
            out_rdy = ($urandom_range(0, 9) < 7);
            flush   = ($urandom_range(0, 31) == 0);
            rst     = (i == 300);
            drive($urandom_range(0, 3) != 0, rnd_pkt());
            tick();
        end
        rst = 1'b0; flush = 1'b0; out_rdy = 1'b1;
        drive(1'b0, '0);
        tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
